// File: rtl/out_port_arbiter_pkg.sv
// Shared constants for the output-port arbiter: default sizing and FSM encodings.
// Imported by the interface, the picker and the arbiter top.
package out_port_arbiter_pkg;

    localparam int PORT_NUB_TOTAL  = 16;
    localparam int PRIORITY        = 8;
    localparam int DATA_LENGTH_MAX = 512;
    localparam int TIMEOUT_CYCLES  = 1023;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/out_port_arbiter_if.sv
// Request/grant bundle between the input modules (master) and one output-port arbiter (slave).
// Per-input fields are packed flat: input i owns [i*WP +: WP] and [i*WL +: WL].
interface out_port_arbiter_if
    import out_port_arbiter_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUB_TOTAL,
    parameter int PRIO_NUM = PRIORITY,
    parameter int LEN_MAX  = DATA_LENGTH_MAX
);
    localparam int WS = $clog2(PORT_NUM);
    localparam int WP = $clog2(PRIO_NUM);
    localparam int WL = $clog2(LEN_MAX);

    logic [PORT_NUM-1:0]    req;
    logic [PORT_NUM*WP-1:0] req_prio;
    logic [PORT_NUM*WL-1:0] req_len;
    logic [PORT_NUM-1:0]    in_vld;
    logic [PORT_NUM-1:0]    grant;
    logic [WS-1:0]          grant_id;
    logic                   busy;
    logic                   pkt_done;
    logic                   timeout_err;

    modport master (
        output req, req_prio, req_len, in_vld,
        input  grant, grant_id, busy, pkt_done, timeout_err
    );

    modport slave (
        input  req, req_prio, req_len, in_vld,
        output grant, grant_id, busy, pkt_done, timeout_err
    );

endinterface

// File: rtl/out_port_arbiter_rr_prio_pick.sv
// Combinational winner selection: highest priority among active requests,
// ties broken by the first active index at or after rr_ptr (wrapping).
module rr_prio_pick
    import out_port_arbiter_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUB_TOTAL,
    parameter int WS       = $clog2(PORT_NUM),
    parameter int WP       = $clog2(PRIORITY)
) (
    input  logic [PORT_NUM-1:0]    req,
    input  logic [PORT_NUM*WP-1:0] req_prio,
    input  logic [WS-1:0]          rr_ptr,
    output logic                   win_vld,
    output logic [WS-1:0]          win_id
);

    logic [WP-1:0] prio_a [PORT_NUM];
    logic [WP-1:0] top_prio;
    logic [WS:0]   scan;
    logic          found;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        win_vld  = |req;
        win_id   = '0;
        top_prio = '0;
        found    = 1'b0;
        scan     = '0;

        for (int i = 0; i < PORT_NUM; i++) begin
            prio_a[i] = req_prio[i*WP +: WP];
        end

        for (int i = 0; i < PORT_NUM; i++) begin
            if (req[i] && prio_a[i] > top_prio) begin
                top_prio = prio_a[i];
            end
        end

        // Walk the ring starting at rr_ptr; the first candidate at top priority wins.
        for (int k = 0; k < PORT_NUM; k++) begin
            scan = {1'b0, rr_ptr} + (WS+1)'(k);
            if (scan >= (WS+1)'(PORT_NUM)) begin
                scan = scan - (WS+1)'(PORT_NUM);
            end
            if (!found && req[scan[WS-1:0]] && prio_a[scan[WS-1:0]] == top_prio) begin
                found  = 1'b1;
                win_id = scan[WS-1:0];
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-port arbiter: IDLE -> ARB -> GRANT -> GAP tenure FSM with beat counter and
// idle watchdog; holds one grant until the packet completes or the watchdog fires.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUB_TOTAL,
    parameter int PRIO_NUM = PRIORITY,
    parameter int LEN_MAX  = DATA_LENGTH_MAX,
    parameter int TIMEOUT  = TIMEOUT_CYCLES
) (
    input logic               clk,
    input logic               rst_n,
    out_port_arbiter_if.slave bus
);

    localparam int WS = $clog2(PORT_NUM);
    localparam int WP = $clog2(PRIO_NUM);
    localparam int WL = $clog2(LEN_MAX);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [WS-1:0] rr_ptr;
    logic [WS-1:0] grant_id_q;
    logic [WL:0]   beat_cnt;
    logic [WW-1:0] wdog;

    logic          win_vld;
    logic [WS-1:0] win_id;
    logic [WL-1:0] len_a [PORT_NUM];
    logic [WL:0]   len_load;
    logic [WS-1:0] rr_next;
    logic          beat;
    logic          last_beat;
    logic          expire;

    rr_prio_pick #(
        .PORT_NUM (PORT_NUM),
        .WS       (WS),
        .WP       (WP)
    ) u_pick (
        .req      (bus.req),
        .req_prio (bus.req_prio),
        .rr_ptr   (rr_ptr),
        .win_vld  (win_vld),
        .win_id   (win_id)
    );

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            len_a[i] = bus.req_len[i*WL +: WL];
        end
        // A zero-length request still occupies one beat.
        len_load  = (len_a[win_id] == '0) ? (WL+1)'(1) : {1'b0, len_a[win_id]};
        rr_next   = (grant_id_q == WS'(PORT_NUM - 1)) ? '0 : grant_id_q + 1'b1;
        beat      = (state == ST_GRANT) && bus.in_vld[grant_id_q];
        last_beat = beat && (beat_cnt == (WL+1)'(1));
        expire    = (state == ST_GRANT) && !beat && (wdog == WW'(TIMEOUT - 1));
    end

    // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id_q <= '0;
            beat_cnt   <= '0;
            wdog       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (win_vld) begin
                        grant_id_q <= win_id;
                        beat_cnt   <= len_load;
                        wdog       <= '0;
                        state      <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        wdog     <= '0;
                    end else if (wdog != WW'(TIMEOUT)) begin
                        wdog <= wdog + 1'b1;
                    end
                    if (last_beat || expire) begin
                        rr_ptr <= rr_next;
                        state  <= ST_GAP;
                    end
                end
                default: begin
                    state <= (|bus.req) ? ST_ARB : ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state == ST_GRANT);
    assign bus.grant       = bus.busy ? (PORT_NUM'(1) << grant_id_q) : '0;
    assign bus.grant_id    = grant_id_q;
    assign bus.pkt_done    = last_beat;
    assign bus.timeout_err = expire;

endmodule
